round_pack_stage: RTL and testbench
===================================

Name: round_pack_stage

Overview:
- Sequential stage directly downstream of the adder's normalizer.
- Takes a normalized sign/exponent/mantissa triple plus sticky bit and performs IEEE-754 round-to-nearest-even, post-rounding renormalization and exception detection.
- Packs the result into a 32-bit single-precision word.
- Valid/ready handshake on both sides; one operation in flight at a time.

Parameters:
- MANTISSA_N, 25, width of the normalized mantissa input (bit 24 = hidden one, bits 23:1 = fraction, bit 0 = guard).
- EXP_N, 8, width of the biased exponent.
- WORD_N, 32, packed output width (1 + EXP_N + MANTISSA_N-2).

Ports:
- clk  input  1  clock, all state updates on rising edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  upstream holds a normalized operand
- in_ready  output  1  stage can accept (high only in IDLE)
- in_sign  input  1  result sign
- in_exp  input  EXP_N  biased exponent from normalizer
- in_mantissa  input  MANTISSA_N  normalized mantissa from normalizer
- in_sticky  input  1  OR of all bits shifted out below guard during alignment
- in_zero  input  1  mantissa was all-zero (first-one finder invalid)
- out_valid  output  1  packed result available
- out_ready  input  1  downstream accepts result
- out_data  output  WORD_N  packed IEEE-754 single
- out_inexact  output  1  guard or sticky was set
- out_overflow  output  1  result saturated to infinity
- out_underflow  output  1  result flushed to zero

Behaviour:
- Reset (async, rst_n low): state=IDLE; in_ready=1; out_valid=0; out_data=0; all flags 0; internal registers cleared. Reset mid-operation discards the in-flight operand, with no output produced.
- FSM states: IDLE, ROUND, RENORM, PACK, OUT.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready, capture all in_* fields and go to ROUND.
- ROUND:
  - Fraction f = mantissa[23:1], guard g = mantissa[0], sticky s.
  - Round up when g & (s | f[0]).
  - Result r = {1'b1,f} + roundup, 25-bit sum.
  - inexact = g | s.
  - If r[24] (carry out), go to RENORM; else go to PACK.
- RENORM:
  - Mantissa = r >> 1.
  - Exponent = exp + 1, computed in EXP_N+1 bits.
  - Go to PACK.
- PACK, in priority order:
  - in_zero -> {sign, 31'b0}, all flags 0.
  - Exponent == 0 -> {sign, 31'b0}, underflow=1 (denormals flushed).
  - Exponent >= 2^EXP_N-1 -> {sign, 8'hFF, 23'b0}, overflow=1, inexact=1.
  - Otherwise -> {sign, exp[7:0], r[22:0]}.
  - Register out_data and flags, then go to OUT.
- OUT:
  - out_valid=1.
  - out_data and flags held stable while out_ready=0.
  - On out_ready=1, go to IDLE; out_valid drops the next cycle.
  - out_data retains its last value after the handshake.
- Latency (accept edge to out_valid high): 3 cycles without renormalization, 4 with.
- Throughput: at most one result per 4 cycles; in_ready=0 in every state other than IDLE. Inputs presented while not ready are ignored.
- in_valid deasserting after capture has no effect.
- Exponent arithmetic never wraps: the carry into bit EXP_N is what drives overflow detection.

Test Plan:
- Plain value: mantissa 25'h1000000, exp 8'd127, sign 0, sticky 0 -> out_data 32'h3F800000, inexact 0, out_valid 3 cycles after accept.
- Round-up on odd tie: mantissa 25'h1000003, exp 127, sticky 0 -> 32'h3F800002, inexact 1.
- Round-down on even tie: mantissa 25'h1000001, sticky 0 -> 32'h3F800000, inexact 1. Same stimulus with sticky 1 -> 32'h3F800001.
- Rounding carry / renorm: mantissa 25'h1FFFFFF, exp 127 -> 32'h40000000, latency 4 cycles. Same with exp 254 -> 32'h7F800000, overflow 1.
- Zero and underflow:
  - in_zero=1, sign 1 -> 32'h80000000, no flags.
  - mantissa 25'h1000000, exp 0 -> 32'h00000000, underflow 1.
- Backpressure and reset:
  - Hold out_ready=0 for 5 cycles in OUT -> out_data/flags stable, in_ready 0, second in_valid ignored.
  - Assert rst_n low during ROUND -> out_valid never rises, in_ready=1 immediately after reset release.

Source files
------------

// File: rtl/round_pack_stage.sv
// round_pack_stage: round-to-nearest-even, renormalize and pack a normalized float into IEEE-754 single
module round_pack_stage #(
  parameter int MANTISSA_N = 25,
  parameter int EXP_N      = 8,
  parameter int WORD_N     = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_sign,
  input  logic [EXP_N-1:0]      in_exp,
  input  logic [MANTISSA_N-1:0] in_mantissa,
  input  logic                  in_sticky,
  input  logic                  in_zero,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WORD_N-1:0]     out_data,
  output logic                  out_inexact,
  output logic                  out_overflow,
  output logic                  out_underflow
);
  typedef enum logic [2:0] {IDLE, ROUND, RENORM, PACK, OUT} state_t;
  state_t state;
  logic sign_q, sticky_q, zero_q, inexact_q;
  logic [EXP_N:0] exp_q;
  logic [MANTISSA_N-1:0] mant_q;
  logic round_up, exp_zero, exp_sat;
  logic [MANTISSA_N-1:0] rounded;
  logic [WORD_N-1:0] pk_data;
  logic pk_inexact, pk_overflow, pk_underflow;
  always_comb begin
    round_up     = mant_q[0] & (sticky_q | mant_q[1]);
    rounded      = {2'b01, mant_q[MANTISSA_N-2:1]} + MANTISSA_N'(round_up);
    exp_zero     = exp_q == '0;
    exp_sat      = exp_q >= {1'b0, {EXP_N{1'b1}}};
    pk_data      = zero_q || exp_zero ? {sign_q, {(WORD_N-1){1'b0}}} :
                   exp_sat ? {sign_q, {EXP_N{1'b1}}, {(MANTISSA_N-2){1'b0}}} :
                   {sign_q, exp_q[EXP_N-1:0], mant_q[MANTISSA_N-3:0]};
    pk_inexact   = zero_q ? 1'b0 : exp_sat && !exp_zero ? 1'b1 : inexact_q;
    pk_overflow  = !zero_q && !exp_zero && exp_sat;
    pk_underflow = !zero_q && exp_zero;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      in_ready      <= 1'b1;
      out_valid     <= 1'b0;
      out_data      <= '0;
      out_inexact   <= 1'b0;
      out_overflow  <= 1'b0;
      out_underflow <= 1'b0;
      sign_q        <= 1'b0;
      sticky_q      <= 1'b0;
      zero_q        <= 1'b0;
      inexact_q     <= 1'b0;
      exp_q         <= '0;
      mant_q        <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          sign_q   <= in_sign;
          exp_q    <= {1'b0, in_exp};
          mant_q   <= in_mantissa;
          sticky_q <= in_sticky;
          zero_q   <= in_zero;
          in_ready <= 1'b0;
          state    <= ROUND;
        end
        ROUND: begin
          mant_q    <= rounded;
          inexact_q <= mant_q[0] | sticky_q;
          state     <= rounded[MANTISSA_N-1] ? RENORM : PACK;
        end
        RENORM: begin
          mant_q <= mant_q >> 1;
          exp_q  <= exp_q + (EXP_N+1)'(1);
          state  <= PACK;
        end
        PACK: begin
          out_data      <= pk_data;
          out_inexact   <= pk_inexact;
          out_overflow  <= pk_overflow;
          out_underflow <= pk_underflow;
          out_valid     <= 1'b1;
          state         <= OUT;
        end
        OUT: if (out_ready) begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_round_pack_stage.sv
// tb_round_pack_stage: directed table-driven checks of rounding, packing, exceptions, backpressure and reset
module tb_round_pack_stage;
  logic clk = 1'b0, rst_n = 1'b0;
  logic in_valid = 1'b0, in_ready, in_sign = 1'b0, in_sticky = 1'b0, in_zero = 1'b0;
  logic [7:0] in_exp = '0;
  logic [24:0] in_mantissa = '0;
  logic out_valid, out_ready = 1'b0, out_inexact, out_overflow, out_underflow;
  logic [31:0] out_data;
  int checks = 0, errors = 0;
  typedef struct {
    logic sign; logic [7:0] e; logic [24:0] m; logic st; logic z;
    logic [31:0] d; logic inx; logic ovf; logic unf; int lat;
  } vec_t;
  vec_t v[11];
  round_pack_stage dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_sign(in_sign), .in_exp(in_exp), .in_mantissa(in_mantissa),
    .in_sticky(in_sticky), .in_zero(in_zero), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_inexact(out_inexact),
    .out_overflow(out_overflow), .out_underflow(out_underflow)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic drive(input vec_t t);
    in_sign = t.sign; in_exp = t.e; in_mantissa = t.m; in_sticky = t.st; in_zero = t.z;
  endtask
  task automatic issue(input vec_t t, output int lat);
    drive(t);
    in_valid = 1'b1;
    lat = 0;
    do begin
      @(posedge clk); #1;
      in_valid = 1'b0;
      lat++;
    end while (!out_valid && lat < 20);
  endtask
  task automatic release_out();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask
  initial begin
    int lat;
    v[0]  = '{1'b0, 8'd127, 25'h1000000, 1'b0, 1'b0, 32'h3F800000, 1'b0, 1'b0, 1'b0, 3};
    v[1]  = '{1'b0, 8'd127, 25'h1000003, 1'b0, 1'b0, 32'h3F800002, 1'b1, 1'b0, 1'b0, 3};
    v[2]  = '{1'b0, 8'd127, 25'h1000001, 1'b0, 1'b0, 32'h3F800000, 1'b1, 1'b0, 1'b0, 3};
    v[3]  = '{1'b0, 8'd127, 25'h1000001, 1'b1, 1'b0, 32'h3F800001, 1'b1, 1'b0, 1'b0, 3};
    v[4]  = '{1'b0, 8'd127, 25'h1FFFFFF, 1'b0, 1'b0, 32'h40000000, 1'b1, 1'b0, 1'b0, 4};
    v[5]  = '{1'b0, 8'd254, 25'h1FFFFFF, 1'b0, 1'b0, 32'h7F800000, 1'b1, 1'b1, 1'b0, 4};
    v[6]  = '{1'b1, 8'd0,   25'h0000000, 1'b0, 1'b1, 32'h80000000, 1'b0, 1'b0, 1'b0, 3};
    v[7]  = '{1'b0, 8'd0,   25'h1000000, 1'b0, 1'b0, 32'h00000000, 1'b0, 1'b0, 1'b1, 3};
    v[8]  = '{1'b0, 8'd255, 25'h1000000, 1'b0, 1'b0, 32'h7F800000, 1'b1, 1'b1, 1'b0, 3};
    v[9]  = '{1'b1, 8'd130, 25'h1400000, 1'b0, 1'b0, 32'hC1200000, 1'b0, 1'b0, 1'b0, 3};
    v[10] = '{1'b0, 8'd255, 25'h1000001, 1'b1, 1'b1, 32'h00000000, 1'b0, 1'b0, 1'b0, 3};
    repeat (2) @(posedge clk);
    #1;
    chk("reset in_ready", 32'(in_ready), 32'd1);
    chk("reset out_valid", 32'(out_valid), 32'd0);
    chk("reset out_data", out_data, 32'h0);
    chk("reset flags", {29'd0, out_inexact, out_overflow, out_underflow}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 11; i++) begin
      issue(v[i], lat);
      chk($sformatf("vec%0d latency", i), 32'(lat), 32'(v[i].lat));
      chk($sformatf("vec%0d out_data", i), out_data, v[i].d);
      chk($sformatf("vec%0d inexact", i), 32'(out_inexact), 32'(v[i].inx));
      chk($sformatf("vec%0d overflow", i), 32'(out_overflow), 32'(v[i].ovf));
      chk($sformatf("vec%0d underflow", i), 32'(out_underflow), 32'(v[i].unf));
      release_out();
      chk($sformatf("vec%0d valid drop", i), 32'(out_valid), 32'd0);
      chk($sformatf("vec%0d ready back", i), 32'(in_ready), 32'd1);
    end
    issue(v[1], lat);
    drive(v[5]);
    in_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      chk("bp out_data", out_data, 32'h3F800002);
      chk("bp inexact", 32'(out_inexact), 32'd1);
      chk("bp out_valid", 32'(out_valid), 32'd1);
      chk("bp in_ready", 32'(in_ready), 32'd0);
    end
    in_valid = 1'b0;
    release_out();
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      chk("bp ignored input", 32'(out_valid), 32'd0);
    end
    chk("bp data retained", out_data, 32'h3F800002);
    drive(v[4]);
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("midop reset in_ready", 32'(in_ready), 32'd1);
    chk("midop reset out_valid", 32'(out_valid), 32'd0);
    chk("midop reset out_data", out_data, 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("post reset in_ready", 32'(in_ready), 32'd1);
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      chk("post reset no output", 32'(out_valid), 32'd0);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
